// File: rtl/tmr_evt_detect_pkg.sv
// Shared event indices and types for the multi-channel timer event detector.
package tmr_evt_pkg;

  localparam int EVT_OVF = 0;
  localparam int EVT_UDF = 1;
  localparam int EVT_CMP = 2;
  localparam int NUM_EVT = 3;

  typedef logic [NUM_EVT-1:0] evt_vec_t;

  // Low 'width' bits set; saturates at 32 bits.
  function automatic logic [31:0] all_ones(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/tmr_evt_detect_ch.sv
// One timer channel: overflow/underflow/compare-edge detection, sticky W1C flags
// and an overrun flag for events that land on an already-set flag.
module tmr_evt_ch
  import tmr_evt_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic [DATA_WIDTH-1:0] tcnt,
  input  logic [DATA_WIDTH-1:0] tcmp,
  input  logic                  cnt_en,
  input  logic                  cnt_dn,
  input  evt_vec_t              clr,
  input  logic                  clr_ovr,
  output evt_vec_t              flag,
  output logic                  ovr_flag
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = {DATA_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] tcnt_d;
  logic                  cmp_d;
  logic                  primed;
  logic                  match;
  logic                  qual;
  evt_vec_t              evt;
  evt_vec_t              pend;

  assign match = (tcnt == tcmp);
  assign qual  = primed && cnt_en;

  always_comb begin
    evt          = '0;
    evt[EVT_OVF] = qual && !cnt_dn && (tcnt_d == CNT_MAX) && (tcnt == '0);
    evt[EVT_UDF] = qual &&  cnt_dn && (tcnt_d == '0) && (tcnt == CNT_MAX);
    evt[EVT_CMP] = qual && match && !cmp_d;
  end

  // An event hitting a flag that is still set and not being cleared is lost.
  assign pend = evt & flag & ~clr;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tcnt_d   <= '0;
      cmp_d    <= 1'b0;
      primed   <= 1'b0;
      flag     <= '0;
      ovr_flag <= 1'b0;
    end else begin
      tcnt_d   <= tcnt;
      cmp_d    <= match;
      primed   <= 1'b1;
      flag     <= evt | (flag & ~clr);
      ovr_flag <= (|pend) | (ovr_flag & ~clr_ovr);
    end
  end

endmodule

// File: rtl/tmr_evt_detect.sv
// Multi-channel timer event detector: per-channel slicing, clear-strobe gating
// and the registered, maskable interrupt request.
module tmr_evt_detect
  import tmr_evt_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                         pclk,
  input  logic                         preset_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] tcnt,
  input  logic [NUM_CH*DATA_WIDTH-1:0] tcmp,
  input  logic [NUM_CH-1:0]            cnt_en,
  input  logic [NUM_CH-1:0]            cnt_dn,
  input  logic                         clr_we,
  input  logic [NUM_CH-1:0]            clr_ovf,
  input  logic [NUM_CH-1:0]            clr_udf,
  input  logic [NUM_CH-1:0]            clr_cmp,
  input  logic [NUM_CH-1:0]            clr_ovr,
  input  logic [NUM_CH-1:0]            ie_ovf,
  input  logic [NUM_CH-1:0]            ie_udf,
  input  logic [NUM_CH-1:0]            ie_cmp,
  output logic [NUM_CH-1:0]            ovf_flag,
  output logic [NUM_CH-1:0]            udf_flag,
  output logic [NUM_CH-1:0]            cmp_flag,
  output logic [NUM_CH-1:0]            ovr_flag,
  output logic                         irq
);

  logic irq_src;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    evt_vec_t clr_i;
    evt_vec_t flag_i;

    assign clr_i[EVT_OVF] = clr_we && clr_ovf[i];
    assign clr_i[EVT_UDF] = clr_we && clr_udf[i];
    assign clr_i[EVT_CMP] = clr_we && clr_cmp[i];

    tmr_evt_ch #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_ch (
      .pclk     (pclk),
      .preset_n (preset_n),
      .tcnt     (tcnt[i*DATA_WIDTH +: DATA_WIDTH]),
      .tcmp     (tcmp[i*DATA_WIDTH +: DATA_WIDTH]),
      .cnt_en   (cnt_en[i]),
      .cnt_dn   (cnt_dn[i]),
      .clr      (clr_i),
      .clr_ovr  (clr_we && clr_ovr[i]),
      .flag     (flag_i),
      .ovr_flag (ovr_flag[i])
    );

    assign ovf_flag[i] = flag_i[EVT_OVF];
    assign udf_flag[i] = flag_i[EVT_UDF];
    assign cmp_flag[i] = flag_i[EVT_CMP];
  end

  // Overrun is status only; it never raises the interrupt.
  assign irq_src = |((ovf_flag & ie_ovf) | (udf_flag & ie_udf) | (cmp_flag & ie_cmp));

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) irq <= 1'b0;
    else           irq <= irq_src;
  end

endmodule

// File: tb/tb_tmr_evt_detect.sv
// Bench for tmr_evt_detect: directed scenarios plus randomized traffic against
// a behavioural model; a second 16-bit single-channel instance covers wide counters.
module tb_tmr_evt_detect;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic [31:0] tcnt, tcmp;
  logic [3:0]  cnt_en, cnt_dn;
  logic        clr_we;
  logic [3:0]  clr_ovf, clr_udf, clr_cmp, clr_ovr;
  logic [3:0]  ie_ovf, ie_udf, ie_cmp;
  logic [3:0]  ovf_flag, udf_flag, cmp_flag, ovr_flag;
  logic        irq;

  logic [15:0] tcnt16, tcmp16;
  logic        en16, dn16, clrwe16, clr_ovf16;
  logic        ovf16, udf16, cmp16, ovr16, irq16;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  tmr_evt_detect #(.DATA_WIDTH(8), .NUM_CH(4)) dut (
    .pclk(pclk), .preset_n(preset_n), .tcnt(tcnt), .tcmp(tcmp),
    .cnt_en(cnt_en), .cnt_dn(cnt_dn), .clr_we(clr_we),
    .clr_ovf(clr_ovf), .clr_udf(clr_udf), .clr_cmp(clr_cmp), .clr_ovr(clr_ovr),
    .ie_ovf(ie_ovf), .ie_udf(ie_udf), .ie_cmp(ie_cmp),
    .ovf_flag(ovf_flag), .udf_flag(udf_flag), .cmp_flag(cmp_flag),
    .ovr_flag(ovr_flag), .irq(irq)
  );

  tmr_evt_detect #(.DATA_WIDTH(16), .NUM_CH(1)) dut16 (
    .pclk(pclk), .preset_n(preset_n), .tcnt(tcnt16), .tcmp(tcmp16),
    .cnt_en(en16), .cnt_dn(dn16), .clr_we(clrwe16),
    .clr_ovf(clr_ovf16), .clr_udf(1'b0), .clr_cmp(1'b0), .clr_ovr(1'b0),
    .ie_ovf(1'b1), .ie_udf(1'b1), .ie_cmp(1'b1),
    .ovf_flag(ovf16), .udf_flag(udf16), .cmp_flag(cmp16),
    .ovr_flag(ovr16), .irq(irq16)
  );

  // Reference model: previous count, previous match, primed, flags, irq.
  int         m_prev[4];
  bit         m_cmpd[4];
  bit         m_primed;
  logic [3:0] m_ovf, m_udf, m_cmp, m_ovr;
  logic       m_irq;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = 0;
      m_cmpd[i] = 0;
    end
    m_primed = 0;
    m_ovf = 0; m_udf = 0; m_cmp = 0; m_ovr = 0; m_irq = 0;
  endtask

  task automatic model_step();
    logic [3:0] n_ovf, n_udf, n_cmp, n_ovr;
    int  cur, cv;
    bit  live, eo, eu, ec, co, cu, cc;
    m_irq = |((m_ovf & ie_ovf) | (m_udf & ie_udf) | (m_cmp & ie_cmp));
    for (int i = 0; i < 4; i++) begin
      cur  = int'(tcnt[i*8 +: 8]);
      cv   = int'(tcmp[i*8 +: 8]);
      live = m_primed && cnt_en[i];
      eo   = live && !cnt_dn[i] && m_prev[i] == 255 && cur == 0;
      eu   = live &&  cnt_dn[i] && m_prev[i] == 0 && cur == 255;
      ec   = live && cur == cv && !m_cmpd[i];
      co   = clr_we && clr_ovf[i];
      cu   = clr_we && clr_udf[i];
      cc   = clr_we && clr_cmp[i];
      n_ovf[i] = eo ? 1'b1 : (co ? 1'b0 : m_ovf[i]);
      n_udf[i] = eu ? 1'b1 : (cu ? 1'b0 : m_udf[i]);
      n_cmp[i] = ec ? 1'b1 : (cc ? 1'b0 : m_cmp[i]);
      if ((eo && m_ovf[i] && !co) || (eu && m_udf[i] && !cu) || (ec && m_cmp[i] && !cc))
        n_ovr[i] = 1'b1;
      else if (clr_we && clr_ovr[i])
        n_ovr[i] = 1'b0;
      else
        n_ovr[i] = m_ovr[i];
      m_prev[i] = cur;
      m_cmpd[i] = (cur == cv);
    end
    m_ovf = n_ovf; m_udf = n_udf; m_cmp = n_cmp; m_ovr = n_ovr;
    m_primed = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_all();
    clr_we = 1; clr_ovf = 4'hF; clr_udf = 4'hF; clr_cmp = 4'hF; clr_ovr = 4'hF;
    tick();
    clr_we = 0; clr_ovf = 0; clr_udf = 0; clr_cmp = 0; clr_ovr = 0;
    tick();
  endtask

  task automatic test_reset();
    preset_n = 0;
    tcnt = 0; tcmp = 32'h8080_8080; cnt_en = 0; cnt_dn = 0;
    clr_we = 0; clr_ovf = 0; clr_udf = 0; clr_cmp = 0; clr_ovr = 0;
    ie_ovf = 0; ie_udf = 0; ie_cmp = 0;
    tcnt16 = 0; tcmp16 = 16'h1234; en16 = 0; dn16 = 0; clrwe16 = 0; clr_ovf16 = 0;
    model_reset();
    @(posedge pclk);
    #1;
    checks++; if (ovf_flag !== 4'h0) begin errors++; $display("FAIL reset_ovf: got %b want 0000", ovf_flag); end
    checks++; if (udf_flag !== 4'h0) begin errors++; $display("FAIL reset_udf: got %b want 0000", udf_flag); end
    checks++; if (cmp_flag !== 4'h0) begin errors++; $display("FAIL reset_cmp: got %b want 0000", cmp_flag); end
    checks++; if (ovr_flag !== 4'h0) begin errors++; $display("FAIL reset_ovr: got %b want 0000", ovr_flag); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    preset_n = 1;
  endtask

  task automatic test_ovf();
    cnt_en = 4'b0001; cnt_dn = 0; ie_ovf = 4'b0001;
    tcnt[7:0] = 8'hFE; tick();
    tcnt[7:0] = 8'hFF; tick();
    checks++; if (ovf_flag !== 4'h0) begin errors++; $display("FAIL ovf_early: got %b want 0000", ovf_flag); end
    tcnt[7:0] = 8'h00; tick();
    checks++; if (ovf_flag !== 4'b0001) begin errors++; $display("FAIL ovf_set: got %b want 0001", ovf_flag); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_lag: got %b want 0", irq); end
    checks++; if ((udf_flag | cmp_flag | ovr_flag) !== 4'h0) begin errors++; $display("FAIL ovf_others: got %b want 0000", udf_flag | cmp_flag | ovr_flag); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b want 1", irq); end
  endtask

  task automatic test_udf_clear();
    clear_all();
    cnt_en = 4'b0010; cnt_dn = 4'b0010; ie_ovf = 0; ie_udf = 4'b0010;
    tcnt[15:8] = 8'h01; tick();
    tcnt[15:8] = 8'h00; tick();
    tcnt[15:8] = 8'hFF; tick();
    checks++; if (udf_flag !== 4'b0010) begin errors++; $display("FAIL udf_set: got %b want 0010", udf_flag); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL udf_irq: got %b want 1", irq); end
    clr_we = 1; clr_udf = 4'b0010; tick();
    clr_we = 0; clr_udf = 0;
    checks++; if (udf_flag !== 4'h0) begin errors++; $display("FAIL udf_clr: got %b want 0000", udf_flag); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL udf_irq_hold: got %b want 1", irq); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL udf_irq_drop: got %b want 0", irq); end
  endtask

  task automatic test_cmp_edge();
    clear_all();
    cnt_en = 4'b0100; cnt_dn = 0; ie_udf = 0; ie_cmp = 4'b0100;
    tcmp[23:16] = 8'h40;
    tcnt[23:16] = 8'h3F; tick();
    checks++; if (cmp_flag !== 4'h0) begin errors++; $display("FAIL cmp_early: got %b want 0000", cmp_flag); end
    tcnt[23:16] = 8'h40; tick();
    checks++; if (cmp_flag !== 4'b0100) begin errors++; $display("FAIL cmp_set: got %b want 0100", cmp_flag); end
    repeat (4) tick();
    checks++; if (ovr_flag !== 4'h0) begin errors++; $display("FAIL cmp_once: ovr got %b want 0000", ovr_flag); end
    clr_we = 1; clr_cmp = 4'b0100; tick();
    clr_we = 0; clr_cmp = 0;
    repeat (3) tick();
    checks++; if (cmp_flag !== 4'h0) begin errors++; $display("FAIL cmp_held_clr: got %b want 0000", cmp_flag); end
  endtask

  task automatic test_set_wins_overrun();
    clear_all();
    cnt_en = 4'b0001; cnt_dn = 0;
    ie_ovf = 4'hF; ie_udf = 4'hF; ie_cmp = 4'hF;
    tcnt[7:0] = 8'hFF; tick();
    tcnt[7:0] = 8'h00; clr_we = 1; clr_ovf = 4'b0001; tick();
    clr_we = 0; clr_ovf = 0;
    checks++; if (ovf_flag !== 4'b0001) begin errors++; $display("FAIL set_wins: got %b want 0001", ovf_flag); end
    checks++; if (ovr_flag !== 4'h0) begin errors++; $display("FAIL ovr_early: got %b want 0000", ovr_flag); end
    tcnt[7:0] = 8'hFF; tick();
    tcnt[7:0] = 8'h00; tick();
    checks++; if (ovr_flag !== 4'b0001) begin errors++; $display("FAIL ovr_set: got %b want 0001", ovr_flag); end
    clr_we = 1; clr_ovf = 4'b0001; tick();
    clr_we = 0; clr_ovf = 0;
    tick();
    checks++; if (ovf_flag !== 4'h0) begin errors++; $display("FAIL ovr_ovf_clr: got %b want 0000", ovf_flag); end
    checks++; if (ovr_flag !== 4'b0001) begin errors++; $display("FAIL ovr_hold: got %b want 0001", ovr_flag); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovr_no_irq: got %b want 0", irq); end
  endtask

  task automatic test_enable_dir_reset();
    clear_all();
    cnt_en = 0; cnt_dn = 0;
    tcnt[7:0] = 8'hFF; tick();
    tcnt[7:0] = 8'h00; tick();
    checks++; if (ovf_flag !== 4'h0) begin errors++; $display("FAIL en_off: got %b want 0000", ovf_flag); end
    cnt_en = 4'b0001;
    tcnt[7:0] = 8'hFF; tick();
    tcnt[7:0] = 8'h00; tick();
    cnt_dn = 4'b0001; tick(); tick();
    checks++; if (ovf_flag !== 4'b0001) begin errors++; $display("FAIL dir_hold: got %b want 0001", ovf_flag); end
    checks++; if (udf_flag !== 4'h0) begin errors++; $display("FAIL dir_udf: got %b want 0000", udf_flag); end
    cnt_dn = 0;
    tcnt[7:0] = 8'hFF; tick();
    tcnt[7:0] = 8'h00;
    preset_n = 0;
    #2;
    checks++; if ((ovf_flag | udf_flag | cmp_flag | ovr_flag) !== 4'h0) begin errors++; $display("FAIL midrst_flags: got %b want 0000", ovf_flag | udf_flag | cmp_flag | ovr_flag); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b want 0", irq); end
    model_reset();
    @(posedge pclk);
    #1;
    preset_n = 1;
    // First post-reset cycle: conditions that would fire if unprimed.
    cnt_en = 4'b0111; cnt_dn = 4'b0010;
    tcnt[15:8] = 8'hFF; tcmp[23:16] = 8'h40; tcnt[23:16] = 8'h40;
    tick();
    checks++; if ((ovf_flag | udf_flag | cmp_flag) !== 4'h0) begin errors++; $display("FAIL unprimed: got %b want 0000", ovf_flag | udf_flag | cmp_flag); end
    tick();
    checks++; if ((ovf_flag | udf_flag | cmp_flag) !== 4'h0) begin errors++; $display("FAIL post_prime: got %b want 0000", ovf_flag | udf_flag | cmp_flag); end
  endtask

  task automatic test_random();
    logic [7:0] v;
    ie_ovf = 4'($urandom); ie_udf = 4'($urandom); ie_cmp = 4'($urandom);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        cnt_en[i] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 9) == 0) cnt_dn[i] = ~cnt_dn[i];
        case ($urandom_range(0, 5))
          0: v = 8'h00;
          1: v = 8'hFF;
          2: v = 8'h01;
          3: v = 8'hFE;
          4: v = tcmp[i*8 +: 8];
          default: v = 8'($urandom);
        endcase
        tcnt[i*8 +: 8] = v;
        if ($urandom_range(0, 7) == 0) tcmp[i*8 +: 8] = 8'($urandom);
      end
      clr_we  = ($urandom_range(0, 3) == 0);
      clr_ovf = 4'($urandom); clr_udf = 4'($urandom);
      clr_cmp = 4'($urandom); clr_ovr = 4'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        ie_ovf = 4'($urandom); ie_udf = 4'($urandom); ie_cmp = 4'($urandom);
      end
      tick();
      checks++; if (ovf_flag !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b want %b", n, ovf_flag, m_ovf); end
      checks++; if (udf_flag !== m_udf) begin errors++; $display("FAIL rnd_udf[%0d]: got %b want %b", n, udf_flag, m_udf); end
      checks++; if (cmp_flag !== m_cmp) begin errors++; $display("FAIL rnd_cmp[%0d]: got %b want %b", n, cmp_flag, m_cmp); end
      checks++; if (ovr_flag !== m_ovr) begin errors++; $display("FAIL rnd_ovr[%0d]: got %b want %b", n, ovr_flag, m_ovr); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq[%0d]: got %b want %b", n, irq, m_irq); end
    end
    clr_we = 0;
  endtask

  task automatic test_w16();
    en16 = 1; dn16 = 0;
    tcnt16 = 16'hFFFF; tick();
    tcnt16 = 16'h0000; tick();
    checks++; if (ovf16 !== 1'b1) begin errors++; $display("FAIL w16_ovf: got %b want 1", ovf16); end
    clrwe16 = 1; clr_ovf16 = 1; tick();
    clrwe16 = 0; clr_ovf16 = 0;
    checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL w16_clr: got %b want 0", ovf16); end
    tcnt16 = 16'h00FF; tick();
    tcnt16 = 16'h0100; tick();
    checks++; if ((ovf16 | udf16) !== 1'b0) begin errors++; $display("FAIL w16_ff_100: got %b want 0", ovf16 | udf16); end
  endtask

  initial begin
    test_reset();
    test_ovf();
    test_udf_clear();
    test_cmp_edge();
    test_set_wins_overrun();
    test_enable_dir_reset();
    test_random();
    test_w16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr_evt_detect.md
Name: tmr_evt_detect

Overview:
Multi-channel timer event detector, parametrised successor to the single 8-bit overflow/underflow comparator. For each of NUM_CH timer channels it detects overflow (max->0 while counting up), underflow (0->max while counting down) and compare match (entry into TCNT==TCMP). Each event sets a sticky flag, cleared by write-1-to-clear. An overrun flag records an event that arrives while its flag is still set. A maskable, registered interrupt line feeds the APB timer wrapper and interrupt controller.

Parameters:
DATA_WIDTH, 8, counter/compare width per channel
NUM_CH, 4, number of independent timer channels (1..16)

Ports:
pclk  in  1  system clock
preset_n  in  1  reset, asynchronous, active-low
tcnt  in  NUM_CH*DATA_WIDTH  current counter values, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
tcmp  in  NUM_CH*DATA_WIDTH  compare values, same packing
cnt_en  in  NUM_CH  per-channel count enable
cnt_dn  in  NUM_CH  per-channel direction: 0 up, 1 down
clr_we  in  1  single-cycle clear strobe, from APB write to status register
clr_ovf  in  NUM_CH  W1C mask for ovf_flag, sampled when clr_we=1
clr_udf  in  NUM_CH  W1C mask for udf_flag
clr_cmp  in  NUM_CH  W1C mask for cmp_flag
clr_ovr  in  NUM_CH  W1C mask for ovr_flag
ie_ovf  in  NUM_CH  interrupt enable, overflow
ie_udf  in  NUM_CH  interrupt enable, underflow
ie_cmp  in  NUM_CH  interrupt enable, compare
ovf_flag  out  NUM_CH  sticky overflow flags
udf_flag  out  NUM_CH  sticky underflow flags
cmp_flag  out  NUM_CH  sticky compare-match flags
ovr_flag  out  NUM_CH  sticky overrun flags
irq  out  1  registered interrupt request

Behaviour:
- Reset (preset_n=0, asynchronous): all flags, irq, tcnt_d, cmp_d and primed = 0.
- Per channel, every cycle: tcnt_d <= tcnt; cmp_d <= (tcnt==tcmp); primed <= 1.
- Events are qualified by primed=1 and cnt_en=1. No event can fire in the first cycle after reset.
  - ovf_evt = !cnt_dn && tcnt_d=={DATA_WIDTH{1}} && tcnt==0
  - udf_evt = cnt_dn && tcnt_d==0 && tcnt=={DATA_WIDTH{1}}
  - cmp_evt = (tcnt==tcmp) && !cmp_d. Rising edge of match only; a held match does not re-fire.
- Latency: the flag is visible one cycle after the sample where the event condition is true.
- Flag update, per flag f with event e and clear c = clr_we & clr_f[i]:
  - e=1: f <= 1. Set wins over a simultaneous clear.
  - else c=1: f <= 0.
  - else hold.
- Direction change and cnt_en=0 do not clear flags. The old auto-clear of the opposite flag on mode change is removed; software clears explicitly.
- Overrun: ovr_flag[i] <= 1 when any of ovf/udf/cmp events fires while its flag is already 1 and not being cleared that cycle. Cleared by clr_ovr under the same set-wins rule.
- Comparisons are unsigned, full DATA_WIDTH. tcmp changing while the counter is held may produce a match edge; this is intended.
- irq is registered: irq <= |((ovf_flag&ie_ovf)|(udf_flag&ie_udf)|(cmp_flag&ie_cmp)). It therefore lags the flags by one cycle. ovr_flag does not drive irq.
- Channels are fully independent. No arbitration or ordering between channels.
- Reset mid-operation returns all state to reset values at once. Detection restarts only after primed is set again.

Decomposition:
- Package tmr_evt_pkg: localparams EVT_OVF=0, EVT_UDF=1, EVT_CMP=2, NUM_EVT=3; typedef evt_vec_t (logic [NUM_EVT-1:0]); helper function all_ones(width).
- Sub-module tmr_evt_ch: one channel (detect + flags + overrun), instantiated NUM_CH times by generate. The top level holds only slicing, the clear-mask fan-out and the irq register.

Test Plan:
1. Ch0 up, cnt_en=1, tcnt FE->FF->00 -> ovf_flag[0]=1 one cycle after the 00 sample; irq=1 one cycle later with ie_ovf[0]=1; other channels' flags stay 0.
2. Ch1 down, tcnt 01->00->FF -> udf_flag[1]=1. Then clr_we=1, clr_udf=0010 -> flag 0 next cycle and irq deasserts one cycle after that.
3. Ch2 tcmp=0x40, tcnt held at 0x40 for 5 cycles -> cmp_flag[2] set exactly once. Clear it while still matching -> stays 0.
4. Ch0 overflow on the same cycle as clr_we with clr_ovf[0]=1 -> ovf_flag[0] remains 1 (set wins). A second overflow before any clear -> ovr_flag[0]=1 and irq unaffected by ovr.
5. cnt_en=0 during FF->00 -> no flag set. Direction toggled with ovf_flag=1 -> flag held. Reset asserted mid-count with tcnt=00 after FF -> all outputs 0 and no event in the first post-reset cycle.
6. DATA_WIDTH=16, NUM_CH=1: tcnt FFFF->0000 up -> ovf_flag=1. FF->100 -> no flag.
